// File: rtl/regwr_arbiter.sv
// rtl/regwr_arbiter.sv - two-requester register-file write arbiter with 1-entry holding buffers
// Optional REGWR_ARB_RR_EN: round-robin on contention (default build: fixed priority, A wins).
module regwr_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [4:0]       a_addr,
  input  logic [31:0]      a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [4:0]       b_addr,
  input  logic [31:0]      b_data,
  output logic             rf_wr_en,
  output logic [4:0]       rf_addrD,
  output logic [31:0]      rf_dataD,
  output logic             busy,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic        a_full, b_full;
  logic [4:0]  a_addr_q, b_addr_q;
  logic [31:0] a_data_q, b_data_q;
  logic        grant_a, grant_b;
  logic        a_load, b_load;

`ifdef REGWR_ARB_RR_EN
  // last_b set means B won the most recent grant, so A wins the next tie.
  logic last_b;

  always_comb begin
    grant_a = a_full && (!b_full || last_b);
    grant_b = b_full && (!a_full || !last_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b <= 1'b1;
    end else if (grant_a) begin
      last_b <= 1'b0;
    end else if (grant_b) begin
      last_b <= 1'b1;
    end
  end
`else
  always_comb begin
    grant_a = a_full;
    grant_b = b_full && !a_full;
  end
`endif

  // Ready looks only at buffer state and grant, never at valid.
  assign a_ready = !a_full || grant_a;
  assign b_ready = !b_full || grant_b;
  // Writes to register 0 complete the handshake but are dropped.
  assign a_load  = a_valid && a_ready && (a_addr != 5'd0);
  assign b_load  = b_valid && b_ready && (b_addr != 5'd0);
  assign busy    = a_full || b_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_full       <= 1'b0;
      a_addr_q     <= '0;
      a_data_q     <= '0;
      b_full       <= 1'b0;
      b_addr_q     <= '0;
      b_data_q     <= '0;
      rf_wr_en     <= 1'b0;
      rf_addrD     <= '0;
      rf_dataD     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (a_load) begin
        a_full   <= 1'b1;
        a_addr_q <= a_addr;
        a_data_q <= a_data;
      end else if (grant_a) begin
        a_full <= 1'b0;
      end

      if (b_load) begin
        b_full   <= 1'b1;
        b_addr_q <= b_addr;
        b_data_q <= b_data;
      end else if (grant_b) begin
        b_full <= 1'b0;
      end

      rf_wr_en <= grant_a || grant_b;
      if (grant_a) begin
        rf_addrD <= a_addr_q;
        rf_dataD <= a_data_q;
      end else if (grant_b) begin
        rf_addrD <= b_addr_q;
        rf_dataD <= b_data_q;
      end

      if (a_full && b_full && (conflict_cnt != {CNT_W{1'b1}})) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_regwr_arbiter.sv
// tb/tb_regwr_arbiter.sv - randomized and directed checks of regwr_arbiter against a queue model
module tb_regwr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, rf_wr_en, busy;
  logic [4:0]  rf_addrD;
  logic [31:0] rf_dataD;
  logic [15:0] conflict_cnt;
  logic        a_ready2, b_ready2, rf_wr_en2, busy2;
  logic [4:0]  rf_addrD2;
  logic [31:0] rf_dataD2;
  logic [1:0]  conflict_cnt2;

  always #5 clk = ~clk;

  regwr_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_wr_en(rf_wr_en), .rf_addrD(rf_addrD), .rf_dataD(rf_dataD),
    .busy(busy), .conflict_cnt(conflict_cnt)
  );

  regwr_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready2), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready2), .b_addr(b_addr), .b_data(b_data),
    .rf_wr_en(rf_wr_en2), .rf_addrD(rf_addrD2), .rf_dataD(rf_dataD2),
    .busy(busy2), .conflict_cnt(conflict_cnt2)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         qa[$];
  wr_t         qb[$];
  logic        m_wr_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_cnt, m_cnt2;
  bit          m_last_a;
  bit          acc_a, acc_b;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_wr_en  = 1'b0;
    m_addr   = '0;
    m_data   = '0;
    m_cnt    = 0;
    m_cnt2   = 0;
    m_last_a = 1'b0;
  endtask

  // One clock: drive inputs, compare outputs to the model, then advance the model.
  task automatic step(input bit av, input logic [4:0] aad, input logic [31:0] ad,
                      input bit bv, input logic [4:0] bad, input logic [31:0] bd);
    int win;
    bit ra, rb;
    @(posedge clk);
    #1;
    a_valid = av; a_addr = aad; a_data = ad;
    b_valid = bv; b_addr = bad; b_data = bd;
    @(negedge clk);
    if (qa.size() > 0 && qb.size() > 0) begin
`ifdef REGWR_ARB_RR_EN
      win = m_last_a ? 2 : 1;
`else
      win = 1;
`endif
    end else if (qa.size() > 0) begin
      win = 1;
    end else if (qb.size() > 0) begin
      win = 2;
    end else begin
      win = 0;
    end
    ra = (qa.size() == 0) || (win == 1);
    rb = (qb.size() == 0) || (win == 2);
    check("a_ready", a_ready, ra);
    check("b_ready", b_ready, rb);
    check("busy", busy, (qa.size() > 0) || (qb.size() > 0));
    check("rf_wr_en", rf_wr_en, m_wr_en);
    check("rf_addrD", rf_addrD, m_addr);
    check("rf_dataD", rf_dataD, m_data);
    check("conflict_cnt", conflict_cnt, m_cnt);
    check("conflict_cnt_w2", conflict_cnt2, m_cnt2);

    if (qa.size() > 0 && qb.size() > 0) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    m_wr_en = (win != 0);
    if (win == 1) begin
      m_addr = qa[0].addr;
      m_data = qa[0].data;
      void'(qa.pop_front());
      m_last_a = 1'b1;
    end else if (win == 2) begin
      m_addr = qb[0].addr;
      m_data = qb[0].data;
      void'(qb.pop_front());
      m_last_a = 1'b0;
    end
    acc_a = av && ra;
    acc_b = bv && rb;
    if (acc_a && aad != 5'd0) qa.push_back({aad, ad});
    if (acc_b && bad != 5'd0) qb.push_back({bad, bd});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    model_reset();
    check("rst_rf_wr_en", rf_wr_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_conflict_cnt", conflict_cnt, 16'd0);
    check("rst_rf_dataD", rf_dataD, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int ia, ib;
    rst = 1'b1;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rf_wr_en", rf_wr_en, 1'b0);
    check("reset_rf_addrD", rf_addrD, 5'd0);
    check("reset_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single write with two-cycle latency to rf_*
    step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
    idle(2);
    check("single_wr_en", rf_wr_en, 1'b1);
    check("single_addr", rf_addrD, 5'd5);
    check("single_data", rf_dataD, 32'hDEADBEEF);
    idle(1);
    check("single_wr_en_off", rf_wr_en, 1'b0);

    // Register 0 writes are swallowed
    for (int i = 0; i < 3; i++) step(0, 5'd0, 32'd0, 1, 5'd0, 32'h1234);
    idle(2);
    check("x0_no_write", rf_wr_en, 1'b0);

    // Streaming from A alone
    for (int i = 0; i < 8; i++) step(1, 5'(i + 1), 32'(i), 0, 5'd0, 32'd0);
    idle(3);

    // Contention: each side advances only when its transfer was accepted
    ia = 0;
    ib = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, 5'(1 + ia), 32'(100 + ia), 1, 5'(17 + ib), 32'(200 + ib));
      if (acc_a) ia++;
      if (acc_b) ib++;
    end
    check("sat_cnt_w2", conflict_cnt2, 2'd3);
    idle(4);

    // Reset with both buffers full
    step(1, 5'd3, 32'hAAAA0003, 1, 5'd4, 32'hBBBB0004);
    step(1, 5'd6, 32'hAAAA0006, 1, 5'd7, 32'hBBBB0007);
    do_reset();
    idle(3);
    check("post_rst_no_write", rf_wr_en, 1'b0);

    // Randomized traffic with one reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
